// File: rtl/mac_seq_pkg.sv
// Shared ALU operation codes and the mac_seq state encoding.
package mac_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_BSEL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_RESP = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mac_seq.sv
// Shift-add multiply-accumulate sequencer driving an external ALU, one ADD per cycle.
// Fixed latency: DATA_W MUL cycles + 1 ACC cycle; result held in RESP until resp_ready.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ALU_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DATA_W-1:0]    req_a,
  input  logic [DATA_W-1:0]    req_b,
  input  logic                 req_clr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    acc_out,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [ALU_SEL_W-1:0] alu_sel,
  input  logic [DATA_W-1:0]    alu_res
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mac_state_t        state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  // Held low through the reset cycle so no request is taken while the FSM clears.
  assign req_ready = (state == ST_IDLE) && !reset;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = ALU_SEL_W'(ALU_ADD);
    case (state)
      ST_MUL: begin
        alu_a = partial;
        alu_b = mplier[0] ? mcand : '0;
      end
      ST_ACC: begin
        alu_a = acc;
        alu_b = partial;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      partial    <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      acc_out    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mcand   <= req_a;
            mplier  <= req_b;
            partial <= '0;
            cnt     <= '0;
            if (req_clr) acc <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          partial <= alu_res;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= ST_ACC;
        end
        ST_ACC: begin
          acc        <= alu_res;
          acc_out    <= alu_res;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Randomized and directed bench for mac_seq with a behavioural ALU and accumulator model.
module tb_mac_seq;
  import mac_seq_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          req_clr = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] acc_out;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [3:0]    alu_sel;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] acc_model = '0;

  always #5 clk = ~clk;

  mac_seq #(.DATA_W(DW), .ALU_SEL_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_clr(req_clr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .acc_out(acc_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res)
  );

  // Behavioural ALU sitting where mac_top would place the real one.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_SLL:  alu_res = alu_a << alu_b[4:0];
      ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_BSEL: alu_res = alu_b;
      default:  alu_res = '0;
    endcase
  end

  function automatic logic [DW-1:0] model_mac(input logic [DW-1:0] a, b, input logic clr);
    logic [DW-1:0] base;
    base = clr ? '0 : acc_model;
    return base + a * b;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_req(input logic [DW-1:0] a, b, input logic clr, output bit ok);
    int w;
    req_a = a; req_b = b; req_clr = clr; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Latency counts cycles from the accept cycle to the first cycle showing resp_valid.
  task automatic run_mac(input logic [DW-1:0] a, b, input logic clr,
                         output logic [DW-1:0] res, output int lat, output bit ok);
    bit acc_ok;
    start_req(a, b, clr, acc_ok);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    ok = acc_ok && resp_valid;
    res = acc_out;
  endtask

  task automatic check_mac(input string name, input logic [DW-1:0] a, b, input logic clr);
    logic [DW-1:0] res, exp;
    int lat;
    bit ok;
    exp = model_mac(a, b, clr);
    run_mac(a, b, clr, res, lat, ok);
    vectors++;
    if (!ok || res !== exp) begin
      miscompares++;
      $display("FAIL %s acc_out: got %h want %h (handshake ok=%0d)", name, res, exp, ok);
    end
    vectors++;
    if (lat !== DW + 2) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, DW + 2);
    end
    acc_model = exp;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_low: got %b want 0", req_ready);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || acc_out !== '0 ||
        alu_a !== '0 || alu_b !== '0 || alu_sel !== ALU_ADD) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b acc=%h a=%h b=%h sel=%h want 1 0 0 0 0 0",
               req_ready, resp_valid, acc_out, alu_a, alu_b, alu_sel);
    end
    acc_model = '0;
  endtask

  task automatic test_directed;
    resp_ready = 1'b1;
    check_mac("p1_3x5_clr", 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    check_mac("p2_7xm2", 32'd7, 32'hFFFF_FFFE, 1'b0);
    vectors++;
    if (acc_out !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL p2_abs: got %h want 00000001", acc_out);
    end
    @(negedge clk);
    check_mac("p3_max_x2", 32'h7FFF_FFFF, 32'd2, 1'b1);
    @(negedge clk);
    check_mac("p3_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    vectors++;
    if (acc_out !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL p3_wrap_abs: got %h want ffffffff", acc_out);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp;
    int bad;
    resp_ready = 1'b0;
    check_mac("bp_req", $urandom, $urandom, 1'b0);
    exp = acc_model;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_clr = 1'(i & 1);
      #1;
      if (resp_valid !== 1'b1 || acc_out !== exp || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d bad cycles want 0 (acc=%h want %h)", bad, acc_out, exp);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: vld=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    check_mac("bp_after", $urandom, $urandom, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    logic [DW-1:0] a, b, exp_part;
    bit ok;
    a = $urandom; b = $urandom;
    start_req(a, b, 1'b0, ok);
    for (int i = 1; i < 13; i++) @(negedge clk);
    exp_part = a * (b & 32'h0000_0FFF);
    vectors++;
    if (!ok || alu_a !== exp_part) begin
      miscompares++;
      $display("FAIL mid_mul_partial: got %h want %h (ok=%0d)", alu_a, exp_part, ok);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || acc_out !== '0 ||
        alu_sel !== ALU_ADD || alu_b !== '0) begin
      miscompares++;
      $display("FAIL mid_mul_reset: rdy=%b vld=%b acc=%h sel=%h b=%h want 1 0 0 0 0",
               req_ready, resp_valid, acc_out, alu_sel, alu_b);
    end
    acc_model = '0;
    check_mac("post_reset_2x3", 32'd2, 32'd3, 1'b0);
    vectors++;
    if (acc_out !== 32'd6) begin
      miscompares++;
      $display("FAIL post_reset_abs: got %h want 00000006", acc_out);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_bus;
    logic [DW-1:0] a, b, mask, exp_b, res;
    int bad_b, bad_sel, lat;
    bit ok;
    a = $urandom | 32'd1;
    b = 32'h0000_00A5;
    mask = '0; bad_b = 0; bad_sel = 0;
    start_req(a, b, 1'b0, ok);
    for (int i = 0; i < DW; i++) begin
      #1;
      if (alu_b !== '0) mask[i] = 1'b1;
      exp_b = b[i] ? (a << i) : '0;
      if (alu_b !== exp_b) bad_b++;
      if (alu_sel !== ALU_ADD) bad_sel++;
      @(negedge clk);
    end
    vectors++;
    if (!ok || mask !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL alu_b_cycles: mask %h want 000000a5", mask);
    end
    vectors++;
    if (bad_b != 0 || bad_sel != 0) begin
      miscompares++;
      $display("FAIL alu_bus_values: %0d bad alu_b, %0d bad alu_sel, want 0 0", bad_b, bad_sel);
    end
    vectors++;
    if (alu_a !== acc_model || alu_b !== a * b || alu_sel !== ALU_ADD) begin
      miscompares++;
      $display("FAIL acc_cycle_bus: a=%h b=%h want %h %h", alu_a, alu_b, acc_model, a * b);
    end
    acc_model = model_mac(a, b, 1'b0);
    lat = 33;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = acc_out;
    vectors++;
    if (res !== acc_model || lat !== DW + 2) begin
      miscompares++;
      $display("FAIL alu_bus_result: acc=%h lat=%0d want %h %0d", res, lat, acc_model, DW + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_mac("b2b", $urandom, $urandom, 1'(i == 0));
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_ready: rdy=%b vld=%b want 1 0", req_ready, resp_valid);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      check_mac("rand", $urandom, $urandom, ($urandom_range(0, 3) == 0));
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_mul();
    test_alu_bus();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Multi-cycle multiply-accumulate sequencer for the RV32 MAC extension.
- It is the initiator on the ALU operand/select interface: it drives the operand A, operand B and select inputs, and consumes the ALU result.
- It computes acc := acc + op_a*op_b (low DATA_W bits) by shift-add, issuing one ALU ADD per cycle.
- Sits beside the execute stage; the core hands it requests through a valid/ready pair and collects results through a second valid/ready pair.

Parameters:
- DATA_W, 32, operand, accumulator and ALU datapath width.
- ALU_SEL_W, 4, width of the ALU select bus.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a MAC request.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  DATA_W  multiplicand.
- req_b  in  DATA_W  multiplier.
- req_clr  in  1  treat the accumulator as 0 for this request.
- resp_valid  out  1  acc_out holds a completed result.
- resp_ready  in  1  core accepts the result.
- acc_out  out  DATA_W  accumulator value.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_sel  out  ALU_SEL_W  ALU operation select.
- alu_res  in  DATA_W  ALU result; combinational from alu_a, alu_b and alu_sel in the same cycle.

Behaviour:
- Reset values: req_ready=0 in the reset cycle, then 1 in IDLE. resp_valid=0, acc_out=0, alu_a=0, alu_b=0, alu_sel=ADD (0000). State=IDLE; internal acc, partial, mcand, mplier and cnt are all 0.
- States: IDLE, MUL, ACC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: mcand<=req_a, mplier<=req_b, partial<=0, cnt<=0.
  - If req_clr, acc<=0.
  - Go to MUL.
- MUL (exactly DATA_W cycles, cnt 0..DATA_W-1):
  - Drive alu_sel=ADD, alu_a=partial, alu_b = mplier[0] ? mcand : 0.
  - Each cycle: partial<=alu_res, mcand<=mcand<<1, mplier<=mplier>>1 (logical), cnt<=cnt+1.
  - At cnt==DATA_W-1, go to ACC.
  - There is no early exit; latency is fixed.
- ACC (1 cycle):
  - Drive alu_sel=ADD, alu_a=acc, alu_b=partial.
  - acc<=alu_res, acc_out<=alu_res, resp_valid<=1.
  - Go to RESP.
- RESP:
  - Hold resp_valid and acc_out until resp_ready.
  - On resp_ready: resp_valid<=0, go to IDLE.
- ALU bus outside MUL and ACC: alu_a=0, alu_b=0, alu_sel=ADD.
- Latency: DATA_W+2 cycles from the accept edge to resp_valid high; 34 for the default.
- Throughput: with resp_ready held high, the next request is accepted 1 cycle after the response handshake.
- Arithmetic:
  - All sums wrap modulo 2^DATA_W.
  - Only the low DATA_W product bits are kept, so the result is identical for signed and unsigned operands.
  - No overflow flag.
- acc persists across requests; it is cleared only by reset or by req_clr.
- req_valid outside IDLE is ignored; req_ready=0 in MUL, ACC and RESP.
- resp_ready while resp_valid=0 is ignored.
- reset in any state, including mid-MUL: next cycle is IDLE, acc=0, resp_valid=0, and the in-flight operation is discarded.
- Reset takes priority over the request and response handshakes in the same cycle.
- alu_a, alu_b and alu_sel are registered-state-derived combinational outputs with no dependency on alu_res.

Decomposition:
- Shared package (extend the existing ALU constants):
  - ALU op codes ALU_ADD=0000, ALU_AND=0001, ALU_OR=0010, ALU_XOR=0011, ALU_SRL=0100, ALU_SRA=0101, ALU_SLL=0110, ALU_SLT=0111, ALU_SUB=1000, ALU_BSEL=1001.
  - mac_seq state encoding.
- No sub-module. The ALU is instantiated by the integrating top (mac_top) and wired to the alu_* ports, which keeps the sequencer testable against a behavioural ALU model.

Test Plan:
1. req_a=3, req_b=5, req_clr=1 -> resp_valid rises exactly 34 cycles after accept; acc_out=15.
2. Follow-up req_a=7, req_b=0xFFFFFFFE (-2), req_clr=0 -> acc_out=0x00000001 (15-14).
3. req_a=0x7FFFFFFF, req_b=2, clr=1 -> acc_out=0xFFFFFFFE; then req_a=0xFFFFFFFF, req_b=0xFFFFFFFF, clr=0 -> acc_out=0xFFFFFFFF (wrap).
4. Hold resp_ready=0 for 10 cycles after resp_valid, pulsing req_valid with different operands -> resp_valid and acc_out stable, req_ready=0, no second request accepted; release resp_ready -> IDLE next cycle.
5. Assert reset at MUL cnt=12 -> next cycle IDLE, req_ready=1, resp_valid=0, acc_out=0, alu_sel=0000; a new 2*3 clr=0 request -> acc_out=6.
6. Monitor the ALU bus through an operation with req_b=0xA5 -> alu_b is non-zero exactly on MUL cycles 0, 2, 5 and 7, and alu_sel=0000 throughout.
